// File: rtl/zap_fetch_main_pkg.sv
// Shared constants for the fetch stage and its branch-predictor storage.
// The branch-state encodings are also used by predecode.
package zap_fetch_main_pkg;

    // 2-bit saturating branch-predictor states.
    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    // CPSR bit that selects Thumb state.
    localparam int unsigned CPSR_T = 5;

    // Value PC+8 takes when the stage is reset or flushed.
    localparam logic [31:0] PC_PLUS_8_CLEAR = 32'd8;

    // Predictor table controller: sweeping the table, or normal operation.
    typedef enum logic {
        FSM_INIT = 1'b0,
        FSM_RUN  = 1'b1
    } bp_fsm_t;

    // Saturating counter step: taken moves toward ST, not-taken toward SNT.
    function automatic logic [1:0] sat_counter(input logic [1:0] cur, input logic taken);
        if (taken) begin
            return (cur == ST) ? ST : cur + 2'd1;
        end
        return (cur == SNT) ? SNT : cur - 2'd1;
    endfunction

endpackage

// File: rtl/zap_branch_state_ram.sv
// Direct-mapped table of 2-bit branch counters: one async read port and
// one sync write port shared between the init sweep and branch updates.
// No reset on purpose; contents are defined only by the init sweep.
module zap_branch_state_ram
    import zap_fetch_main_pkg::*;
#(
    parameter int         BP_ENTRIES = 1024,
    parameter logic [1:0] BP_INIT    = 2'd1,
    parameter int         IDX_W      = $clog2(BP_ENTRIES)
) (
    input  logic             i_clk,
    input  logic             i_init_we,
    input  logic [IDX_W-1:0] i_init_idx,
    input  logic             i_upd_we,
    input  logic [IDX_W-1:0] i_upd_idx,
    input  logic             i_upd_taken,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [1:0]       o_rd_data
);

    logic [1:0] r_mem [BP_ENTRIES];

    // Init sweep writes take precedence; otherwise apply the saturating update.
    always_ff @(posedge i_clk) begin
        if (i_init_we) begin
            r_mem[i_init_idx] <= BP_INIT;
        end else if (i_upd_we) begin
            r_mem[i_upd_idx] <= sat_counter(r_mem[i_upd_idx], i_upd_taken);
        end
    end

    // Read is combinational, so a same-cycle update is seen only after the edge.
    assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/zap_fetch_main.sv
// Fetch stage: registers the memory response for predecode, attaches a
// 2-bit branch prediction and keeps the predictor table trained by the ALU.
module zap_fetch_main
    import zap_fetch_main_pkg::*;
#(
    parameter int         BP_ENTRIES = 1024,
    parameter logic [1:0] BP_INIT    = 2'd1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_clear_from_writeback,
    input  logic        i_data_stall,
    input  logic        i_clear_from_alu,
    input  logic        i_stall_from_shifter,
    input  logic        i_stall_from_issue,
    input  logic        i_clear_from_decode,
    input  logic        i_stall_from_decode,
    input  logic [31:0] i_pc_ff,
    input  logic [31:0] i_instruction,
    input  logic        i_instruction_valid,
    input  logic        i_instruction_abort,
    input  logic [31:0] i_cpu_mode,
    input  logic        i_bp_update_valid,
    input  logic [31:0] i_bp_update_pc,
    input  logic        i_bp_update_taken,
    output logic [31:0] o_instruction_ff,
    output logic        o_instruction_valid_ff,
    output logic [31:0] o_pc_ff,
    output logic [31:0] o_pc_plus_8_ff,
    output logic        o_abt_ff,
    output logic [1:0]  o_taken_ff,
    output logic        o_bp_init_busy
);

    localparam int IDX_W = $clog2(BP_ENTRIES);

    bp_fsm_t          r_state;
    logic [IDX_W-1:0] r_sweep_idx;
    logic             r_bp_init_busy;
    logic             w_clear;
    logic             w_load;
    logic [1:0]       w_rd_data;
    logic             w_unused;

    // Bits the halfword-granular index and the T-bit lookup do not need.
    assign w_unused = ^{i_cpu_mode[31:CPSR_T+1], i_cpu_mode[CPSR_T-1:0],
                        i_bp_update_pc[31:IDX_W+1], i_bp_update_pc[0]};

    zap_branch_state_ram #(
        .BP_ENTRIES (BP_ENTRIES),
        .BP_INIT    (BP_INIT),
        .IDX_W      (IDX_W)
    ) u_bp_ram (
        .i_clk       (i_clk),
        .i_init_we   (r_state == FSM_INIT),
        .i_init_idx  (r_sweep_idx),
        .i_upd_we    ((r_state == FSM_RUN) && i_bp_update_valid),
        .i_upd_idx   (i_bp_update_pc[IDX_W:1]),
        .i_upd_taken (i_bp_update_taken),
        .i_rd_idx    (i_pc_ff[IDX_W:1]),
        .o_rd_data   (w_rd_data)
    );

    // Pipeline-wide clear/stall priority; a hold is neither clear nor load.
    always_comb begin
        w_clear = 1'b0;
        w_load  = 1'b0;
        if (i_clear_from_writeback) begin
            w_clear = 1'b1;
        end else if (i_data_stall) begin
            w_load = 1'b0;
        end else if (i_clear_from_alu) begin
            w_clear = 1'b1;
        end else if (i_stall_from_shifter || i_stall_from_issue) begin
            w_load = 1'b0;
        end else if (i_clear_from_decode) begin
            w_clear = 1'b1;
        end else if (!i_stall_from_decode) begin
            w_load = 1'b1;
        end
    end

    // Table controller: sweep every entry once after reset, then run.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state        <= FSM_INIT;
            r_sweep_idx    <= '0;
            r_bp_init_busy <= 1'b1;
        end else begin
            case (r_state)
                FSM_INIT: begin
                    r_sweep_idx <= r_sweep_idx + IDX_W'(1);
                    if (r_sweep_idx == IDX_W'(BP_ENTRIES - 1)) begin
                        r_state        <= FSM_RUN;
                        r_bp_init_busy <= 1'b0;
                    end
                end
                default: begin
                    r_bp_init_busy <= 1'b0;
                end
            endcase
        end
    end

    // Output register toward predecode: clear, hold or load the memory response.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_instruction_ff       <= '0;
            o_instruction_valid_ff <= 1'b0;
            o_pc_ff                <= '0;
            o_pc_plus_8_ff         <= PC_PLUS_8_CLEAR;
            o_abt_ff               <= 1'b0;
            o_taken_ff             <= SNT;
        end else if (w_clear) begin
            o_instruction_ff       <= '0;
            o_instruction_valid_ff <= 1'b0;
            o_pc_ff                <= '0;
            o_pc_plus_8_ff         <= PC_PLUS_8_CLEAR;
            o_abt_ff               <= 1'b0;
            o_taken_ff             <= SNT;
        end else if (w_load) begin
            o_instruction_ff       <= i_instruction;
            o_instruction_valid_ff <= i_instruction_valid && (r_state != FSM_INIT);
            o_pc_ff                <= i_pc_ff;
            o_pc_plus_8_ff         <= i_pc_ff + (i_cpu_mode[CPSR_T] ? 32'd4 : 32'd8);
            o_abt_ff               <= i_instruction_abort && i_instruction_valid;
            o_taken_ff             <= w_rd_data;
        end
    end

    assign o_bp_init_busy = r_bp_init_busy;

endmodule

// File: tb/tb_zap_fetch_main.sv
// Bench for zap_fetch_main with an 8-entry predictor: a behavioural model
// checked every cycle plus directed vectors with literal expectations.
module tb_zap_fetch_main;

    localparam int N = 8;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_clear_from_writeback = 1'b0;
    logic        i_data_stall = 1'b0;
    logic        i_clear_from_alu = 1'b0;
    logic        i_stall_from_shifter = 1'b0;
    logic        i_stall_from_issue = 1'b0;
    logic        i_clear_from_decode = 1'b0;
    logic        i_stall_from_decode = 1'b0;
    logic [31:0] i_pc_ff = '0;
    logic [31:0] i_instruction = '0;
    logic        i_instruction_valid = 1'b0;
    logic        i_instruction_abort = 1'b0;
    logic [31:0] i_cpu_mode = 32'h10;
    logic        i_bp_update_valid = 1'b0;
    logic [31:0] i_bp_update_pc = '0;
    logic        i_bp_update_taken = 1'b0;
    logic [31:0] o_instruction_ff;
    logic        o_instruction_valid_ff;
    logic [31:0] o_pc_ff;
    logic [31:0] o_pc_plus_8_ff;
    logic        o_abt_ff;
    logic [1:0]  o_taken_ff;
    logic        o_bp_init_busy;

    int vecCount = 0;
    int missCount = 0;

    // Model state
    int          predTable [N];
    int          initLeft;
    int          action;
    int          rdIdx;
    int          updIdx;
    bit          inInit;
    bit          takenKnown;
    logic [31:0] expInstr;
    logic [31:0] expPc;
    logic [31:0] expPc8;
    logic        expValid;
    logic        expAbt;
    logic        expBusy;
    logic [1:0]  expTaken;

    always #5 i_clk = ~i_clk;

    zap_fetch_main #(
        .BP_ENTRIES (N),
        .BP_INIT    (2'd1)
    ) dut (
        .i_clk                  (i_clk),
        .i_reset_n              (i_reset_n),
        .i_clear_from_writeback (i_clear_from_writeback),
        .i_data_stall           (i_data_stall),
        .i_clear_from_alu       (i_clear_from_alu),
        .i_stall_from_shifter   (i_stall_from_shifter),
        .i_stall_from_issue     (i_stall_from_issue),
        .i_clear_from_decode    (i_clear_from_decode),
        .i_stall_from_decode    (i_stall_from_decode),
        .i_pc_ff                (i_pc_ff),
        .i_instruction          (i_instruction),
        .i_instruction_valid    (i_instruction_valid),
        .i_instruction_abort    (i_instruction_abort),
        .i_cpu_mode             (i_cpu_mode),
        .i_bp_update_valid      (i_bp_update_valid),
        .i_bp_update_pc         (i_bp_update_pc),
        .i_bp_update_taken      (i_bp_update_taken),
        .o_instruction_ff       (o_instruction_ff),
        .o_instruction_valid_ff (o_instruction_valid_ff),
        .o_pc_ff                (o_pc_ff),
        .o_pc_plus_8_ff         (o_pc_plus_8_ff),
        .o_abt_ff               (o_abt_ff),
        .o_taken_ff             (o_taken_ff),
        .o_bp_init_busy         (o_bp_init_busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Present one memory response and let one clock edge consume it.
    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] instr,
                                 input logic valid, input logic abort, input logic thumb);
        i_pc_ff             = pc;
        i_instruction       = instr;
        i_instruction_valid = valid;
        i_instruction_abort = abort;
        i_cpu_mode          = thumb ? 32'h0000_0030 : 32'h0000_0010;
        @(negedge i_clk);
    endtask

    task automatic clearControls();
        i_clear_from_writeback = 1'b0;
        i_data_stall           = 1'b0;
        i_clear_from_alu       = 1'b0;
        i_stall_from_shifter   = 1'b0;
        i_stall_from_issue     = 1'b0;
        i_clear_from_decode    = 1'b0;
        i_stall_from_decode    = 1'b0;
        i_bp_update_valid      = 1'b0;
    endtask

    // One resolved-branch report while fetching an unrelated address (entry 1).
    task automatic pulseUpdate(input logic [31:0] pc, input logic taken);
        i_bp_update_valid = 1'b1;
        i_bp_update_pc    = pc;
        i_bp_update_taken = taken;
        applyStimulus(32'h102, 32'hE1A00000, 1'b1, 1'b0, 1'b0);
        i_bp_update_valid = 1'b0;
    endtask

    // Behavioural model: the action each edge takes, a plain counter array,
    // and an init countdown standing in for the sweep.
    always @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            expInstr = '0; expValid = 1'b0; expPc = '0; expPc8 = 32'd8;
            expAbt = 1'b0; expTaken = 2'd0; takenKnown = 1'b1;
            expBusy = 1'b1; initLeft = N;
            for (int i = 0; i < N; i++) predTable[i] = 1;
        end else begin
            inInit = (initLeft > 0);
            // 0 = load, 1 = hold, 2 = clear
            if (i_clear_from_writeback)                        action = 2;
            else if (i_data_stall)                             action = 1;
            else if (i_clear_from_alu)                         action = 2;
            else if (i_stall_from_shifter || i_stall_from_issue) action = 1;
            else if (i_clear_from_decode)                      action = 2;
            else if (i_stall_from_decode)                      action = 1;
            else                                               action = 0;
            rdIdx = int'((i_pc_ff >> 1) % N);
            if (action == 2) begin
                expInstr = '0; expValid = 1'b0; expPc = '0; expPc8 = 32'd8;
                expAbt = 1'b0; expTaken = 2'd0; takenKnown = 1'b1;
            end else if (action == 0) begin
                expInstr   = i_instruction;
                expValid   = i_instruction_valid && !inInit;
                expPc      = i_pc_ff;
                expPc8     = i_pc_ff + (i_cpu_mode[5] ? 32'd4 : 32'd8);
                expAbt     = i_instruction_abort && i_instruction_valid;
                expTaken   = 2'(predTable[rdIdx]);
                takenKnown = !inInit;
            end
            if (!inInit && i_bp_update_valid) begin
                updIdx = int'((i_bp_update_pc >> 1) % N);
                if (i_bp_update_taken) predTable[updIdx] = (predTable[updIdx] >= 3) ? 3 : predTable[updIdx] + 1;
                else                   predTable[updIdx] = (predTable[updIdx] <= 0) ? 0 : predTable[updIdx] - 1;
            end
            if (inInit) initLeft--;
            expBusy = (initLeft > 0);
        end
    end

    // Compare every output against the model shortly after each edge.
    always @(posedge i_clk) begin
        #1;
        checkOutput("m_instr", o_instruction_ff, expInstr);
        checkOutput("m_valid", 32'(o_instruction_valid_ff), 32'(expValid));
        checkOutput("m_pc", o_pc_ff, expPc);
        checkOutput("m_pc8", o_pc_plus_8_ff, expPc8);
        checkOutput("m_abt", 32'(o_abt_ff), 32'(expAbt));
        checkOutput("m_busy", 32'(o_bp_init_busy), 32'(expBusy));
        if (takenKnown) checkOutput("m_taken", 32'(o_taken_ff), 32'(expTaken));
    end

    initial begin
        int busyCycles;
        clearControls();
        repeat (3) @(negedge i_clk);

        $display("[TB] reset values");
        checkOutput("rst_pc8", o_pc_plus_8_ff, 32'd8);
        checkOutput("rst_busy", 32'(o_bp_init_busy), 32'd1);
        checkOutput("rst_valid", 32'(o_instruction_valid_ff), 32'd0);
        checkOutput("rst_pc", o_pc_ff, 32'd0);

        $display("[TB] init sweep with valid instructions presented");
        i_reset_n = 1'b1;
        i_instruction_valid = 1'b1;
        i_pc_ff = 32'h40;
        busyCycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (o_bp_init_busy) busyCycles++;
            if (i > 0) checkOutput("init_valid", 32'(o_instruction_valid_ff), 32'(0));
            if (!o_bp_init_busy && i > 0) break;
            @(negedge i_clk);
        end
        checkOutput("init_len", 32'(busyCycles), 32'd8);

        $display("[TB] every entry reads WNT");
        for (int i = 0; i < N; i++) begin
            applyStimulus(32'(2 * i), 32'hE1A00000, 1'b1, 1'b0, 1'b0);
            checkOutput("init_entry", 32'(o_taken_ff), 32'd1);
        end

        $display("[TB] ARM and Thumb loads");
        applyStimulus(32'h100, 32'hEA000002, 1'b1, 1'b0, 1'b0);
        checkOutput("arm_pc", o_pc_ff, 32'h100);
        checkOutput("arm_pc8", o_pc_plus_8_ff, 32'h108);
        checkOutput("arm_taken", 32'(o_taken_ff), 32'd1);
        checkOutput("arm_valid", 32'(o_instruction_valid_ff), 32'd1);
        checkOutput("arm_instr", o_instruction_ff, 32'hEA000002);
        applyStimulus(32'h100, 32'h0000E7FE, 1'b1, 1'b0, 1'b1);
        checkOutput("thumb_pc8", o_pc_plus_8_ff, 32'h104);
        applyStimulus(32'hFFFF_FFFC, 32'hE1A00000, 1'b1, 1'b0, 1'b0);
        checkOutput("wrap_pc8", o_pc_plus_8_ff, 32'h4);
        applyStimulus(32'h110, 32'hE1A00000, 1'b1, 1'b1, 1'b0);
        checkOutput("abt_valid", 32'(o_abt_ff), 32'd1);
        applyStimulus(32'h114, 32'hE1A00000, 1'b0, 1'b1, 1'b0);
        checkOutput("abt_invalid", 32'(o_abt_ff), 32'd0);

        $display("[TB] counter saturation");
        repeat (3) pulseUpdate(32'h100, 1'b1);
        applyStimulus(32'h100, 32'hEA000002, 1'b1, 1'b0, 1'b0);
        checkOutput("sat_high", 32'(o_taken_ff), 32'd3);
        repeat (4) pulseUpdate(32'h100, 1'b0);
        applyStimulus(32'h100, 32'hEA000002, 1'b1, 1'b0, 1'b0);
        checkOutput("sat_low", 32'(o_taken_ff), 32'd0);

        $display("[TB] same-cycle read and update");
        pulseUpdate(32'h100, 1'b1);
        i_bp_update_valid = 1'b1; i_bp_update_pc = 32'h100; i_bp_update_taken = 1'b1;
        applyStimulus(32'h100, 32'hEA000002, 1'b1, 1'b0, 1'b0);
        i_bp_update_valid = 1'b0;
        checkOutput("rw_old", 32'(o_taken_ff), 32'd1);
        applyStimulus(32'h100, 32'hEA000002, 1'b1, 1'b0, 1'b0);
        checkOutput("rw_new", 32'(o_taken_ff), 32'd2);

        $display("[TB] clear/stall priority");
        applyStimulus(32'h200, 32'hE3A00001, 1'b1, 1'b0, 1'b0);
        i_clear_from_writeback = 1'b1; i_data_stall = 1'b1;
        applyStimulus(32'h204, 32'hE3A00002, 1'b1, 1'b0, 1'b0);
        clearControls();
        checkOutput("wb_clr_pc8", o_pc_plus_8_ff, 32'd8);
        checkOutput("wb_clr_valid", 32'(o_instruction_valid_ff), 32'd0);
        applyStimulus(32'h300, 32'hE3A00003, 1'b1, 1'b0, 1'b0);
        i_data_stall = 1'b1; i_clear_from_alu = 1'b1;
        applyStimulus(32'h400, 32'hE3A00004, 1'b1, 1'b0, 1'b0);
        clearControls();
        checkOutput("dstall_pc", o_pc_ff, 32'h300);
        checkOutput("dstall_valid", 32'(o_instruction_valid_ff), 32'd1);
        i_clear_from_alu = 1'b1; i_stall_from_shifter = 1'b1;
        applyStimulus(32'h404, 32'hE3A00005, 1'b1, 1'b0, 1'b0);
        clearControls();
        checkOutput("alu_clr_pc", o_pc_ff, 32'h0);
        applyStimulus(32'h308, 32'hE3A00006, 1'b1, 1'b0, 1'b0);
        i_stall_from_issue = 1'b1; i_clear_from_decode = 1'b1;
        applyStimulus(32'h40C, 32'hE3A00007, 1'b1, 1'b0, 1'b0);
        clearControls();
        checkOutput("issue_hold_pc", o_pc_ff, 32'h308);

        $display("[TB] decode stall and decode clear");
        applyStimulus(32'h500, 32'hE2811001, 1'b1, 1'b0, 1'b0);
        i_stall_from_decode = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(32'h500 + 32'(4 * i), 32'hE0000000 + 32'(i), 1'b1, 1'b0, 1'b0);
            checkOutput("dec_hold_pc", o_pc_ff, 32'h500);
            checkOutput("dec_hold_instr", o_instruction_ff, 32'hE2811001);
        end
        clearControls();
        i_clear_from_decode = 1'b1;
        i_bp_update_valid = 1'b1; i_bp_update_pc = 32'h100; i_bp_update_taken = 1'b1;
        applyStimulus(32'h600, 32'hE3A00008, 1'b1, 1'b0, 1'b0);
        clearControls();
        checkOutput("dec_clr_valid", 32'(o_instruction_valid_ff), 32'd0);
        applyStimulus(32'h100, 32'hEA000002, 1'b1, 1'b0, 1'b0);
        checkOutput("dec_clr_upd", 32'(o_taken_ff), 32'd3);

        repeat (2) @(negedge i_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
